// File: rtl/ifq_pkg.sv
// Shared types and defaults for the instruction fetch queue.
package ifq_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int ILEN_DEF  = 32;
    localparam int DEPTH_DEF = 4;

    localparam logic [XLEN_DEF-1:0] PC_RST_VEC = '0;

    typedef struct packed {
        logic [XLEN_DEF-1:0] pc;
        logic [ILEN_DEF-1:0] inst;
        logic                filled;
    } ifq_entry_t;

endpackage

// File: rtl/ifq_if.sv
// Fetch-side, memory-side and decode-side handshakes of the fetch queue.
interface ifq_if
    import ifq_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int ILEN = ILEN_DEF
);
    logic            pc_valid;
    logic [XLEN-1:0] pc;
    logic            pc_ready;

    logic            imem_req_valid;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_req_ready;

    logic            imem_rsp_valid;
    logic [ILEN-1:0] imem_rsp_data;

    logic            inst_valid;
    logic [ILEN-1:0] inst;
    logic [XLEN-1:0] inst_pc;
    logic            inst_ready;

    // IFU, memory and decode side
    modport master (
        output pc_valid, pc,
        input  pc_ready,
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid, imem_rsp_data,
        input  inst_valid, inst, inst_pc,
        output inst_ready
    );

    // fetch queue side
    modport slave (
        input  pc_valid, pc,
        output pc_ready,
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid, imem_rsp_data,
        output inst_valid, inst, inst_pc,
        input  inst_ready
    );

endinterface

// File: rtl/ifq.sv
// Instruction fetch queue: issues fetch PCs to memory, buffers returned
// words in order with their PC, and drains them to decode. A flush discards
// buffered entries and counts the still-owed responses so they can be dropped.
module ifq
    import ifq_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int ILEN  = ILEN_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic clk,
    input  logic rst_b,
    input  logic flush,
    ifq_if.slave bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [XLEN-1:0]  pc_mem   [DEPTH];
    logic [ILEN-1:0]  inst_mem [DEPTH];
    logic [DEPTH-1:0] filled;

    logic [PW-1:0] wp, fp, rp, drop_cnt;
    logic [PW-1:0] alloc, inflight, drop_flush;
    logic [AW-1:0] wi, fi, ri;
    logic          live, space, req_fire, pop, rsp_keep, rsp_drop;

    assign alloc    = wp - rp;
    assign inflight = wp - fp;
    assign wi       = wp[AW-1:0];
    assign fi       = fp[AW-1:0];
    assign ri       = rp[AW-1:0];

    // Outstanding pre-flush responses still occupy capacity until they return.
    assign live  = ~rst_b & ~flush;
    assign space = (alloc + drop_cnt) < PW'(DEPTH);

    assign bus.pc_ready       = bus.imem_req_ready & space & live;
    assign bus.imem_req_valid = bus.pc_valid & space & live;
    assign bus.imem_req_addr  = bus.pc;

    assign bus.inst_valid = filled[ri] & (alloc != '0) & live;
    assign bus.inst       = inst_mem[ri];
    assign bus.inst_pc    = pc_mem[ri];

    assign req_fire = bus.pc_valid & bus.pc_ready;
    assign pop      = bus.inst_valid & bus.inst_ready;
    assign rsp_keep = bus.imem_rsp_valid & live & (drop_cnt == '0);
    assign rsp_drop = bus.imem_rsp_valid & live & (drop_cnt != '0);

    // Owed responses after a flush: everything in flight, less one arriving now.
    always_comb begin
        drop_flush = drop_cnt + inflight;
        if (bus.imem_rsp_valid && (drop_flush != '0))
            drop_flush = drop_flush - PW'(1);
    end

    // Ring storage, pointers and drop counter.
    always_ff @(posedge clk or posedge rst_b) begin
        if (rst_b) begin
            wp       <= '0;
            fp       <= '0;
            rp       <= '0;
            drop_cnt <= '0;
            filled   <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                pc_mem[AW'(i)]   <= XLEN'(PC_RST_VEC);
                inst_mem[AW'(i)] <= '0;
            end
        end else if (flush) begin
            rp       <= wp;
            fp       <= wp;
            filled   <= '0;
            drop_cnt <= drop_flush;
        end else begin
            if (req_fire) begin
                pc_mem[wi] <= bus.pc;
                filled[wi] <= 1'b0;
                wp         <= wp + PW'(1);
            end
            if (rsp_keep) begin
                inst_mem[fi] <= bus.imem_rsp_data;
                filled[fi]   <= 1'b1;
                fp           <= fp + PW'(1);
            end
            if (rsp_drop)
                drop_cnt <= drop_cnt - PW'(1);
            if (pop)
                rp <= rp + PW'(1);
        end
    end

    // Memory must never return a word that no request is waiting for.
    a_rsp_expected: assert property (@(posedge clk) disable iff (rst_b)
        bus.imem_rsp_valid |-> ((inflight != '0) || (drop_cnt != '0)));

endmodule

// File: tb/tb_ifq.sv
// Self-checking bench for ifq: queue-based reference model checked every
// cycle, a 1-cycle in-order memory responder, and directed scenarios.
module tb_ifq;
    import ifq_pkg::*;

    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst_b;
    logic flush;

    ifq_if #(.XLEN(32), .ILEN(32)) bus ();

    ifq #(.XLEN(32), .ILEN(32), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_b (rst_b),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return 32'hC0DE_0000 | {16'h0000, a[15:0]};
    endfunction

    // Reference model: ordered list of allocated fetches plus owed-response count.
    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        bit          filled;
    } ment_t;

    ment_t       mq[$];
    int          m_drop = 0;

    bit          mem_en = 1'b0;
    logic [31:0] mem_q[$];

    bit          s_rst, s_flush, s_fire, s_pop, s_rsp, s_mreq;
    logic [31:0] s_pc, s_data, s_maddr;

    // Compare DUT outputs against the model mid-cycle, then latch this cycle's events.
    always @(negedge clk) begin : compare
        bit live, space, e_ready, e_reqv, e_iv;
        live    = !rst_b && !flush;
        space   = (mq.size() + m_drop) < DEPTH;
        e_ready = live && space && bus.imem_req_ready;
        e_reqv  = live && space && bus.pc_valid;
        e_iv    = live && (mq.size() > 0) && mq[0].filled;
        chk("pc_ready", {31'b0, bus.pc_ready}, {31'b0, e_ready});
        chk("imem_req_valid", {31'b0, bus.imem_req_valid}, {31'b0, e_reqv});
        if (e_reqv) chk("imem_req_addr", bus.imem_req_addr, bus.pc);
        chk("inst_valid", {31'b0, bus.inst_valid}, {31'b0, e_iv});
        if (e_iv) begin
            chk("inst", bus.inst, mq[0].inst);
            chk("inst_pc", bus.inst_pc, mq[0].pc);
        end
        if (rst_b) begin
            chk("rst_inst", bus.inst, 32'h0);
            chk("rst_inst_pc", bus.inst_pc, 32'h0);
        end
        s_rst   = rst_b;
        s_flush = flush;
        s_fire  = e_reqv && bus.imem_req_ready;
        s_pc    = bus.pc;
        s_pop   = e_iv && bus.inst_ready;
        s_rsp   = (bus.imem_rsp_valid === 1'b1);
        s_data  = bus.imem_rsp_data;
        s_mreq  = (bus.imem_req_valid === 1'b1) && (bus.imem_req_ready === 1'b1);
        s_maddr = bus.imem_req_addr;
    end

    // Model state update at the clock edge.
    always @(posedge clk) begin : model
        if (s_rst) begin
            mq.delete();
            m_drop = 0;
        end else if (s_flush) begin
            int unf;
            unf = 0;
            foreach (mq[i]) if (!mq[i].filled) unf++;
            m_drop = m_drop + unf - (s_rsp ? 1 : 0);
            if (m_drop < 0) m_drop = 0;
            mq.delete();
        end else begin
            if (s_rsp) begin
                if (m_drop > 0) m_drop--;
                else begin
                    for (int i = 0; i < mq.size(); i++) begin
                        if (!mq[i].filled) begin
                            mq[i].inst   = s_data;
                            mq[i].filled = 1'b1;
                            break;
                        end
                    end
                end
            end
            if (s_pop) void'(mq.pop_front());
            if (s_fire) mq.push_back('{pc: s_pc, inst: 32'h0, filled: 1'b0});
        end
    end

    // In-order memory with one cycle of latency, gated by mem_en.
    always @(posedge clk) begin : memory
        if (s_rst) mem_q.delete();
        else begin
            if (s_rsp && mem_q.size() > 0) void'(mem_q.pop_front());
            if (s_mreq) mem_q.push_back(s_maddr);
        end
        #2;
        if (!rst_b && mem_en && mem_q.size() > 0) begin
            bus.imem_rsp_valid = 1'b1;
            bus.imem_rsp_data  = word_of(mem_q[0]);
        end else begin
            bus.imem_rsp_valid = 1'b0;
            bus.imem_rsp_data  = 32'h0;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    logic [31:0] got[$];

    // Drain with inst_ready=1 until n words collected or budget expires.
    task automatic collect(input int n, input int maxc, input string name);
        got.delete();
        bus.inst_ready = 1'b1;
        for (int c = 0; c < maxc && got.size() < n; c++) begin
            settle();
            if (bus.inst_valid) begin
                got.push_back(bus.inst_pc);
                chk({name, "_word"}, bus.inst, word_of(bus.inst_pc));
            end
            cyc();
        end
        bus.inst_ready = 1'b0;
        chk({name, "_count"}, got.size(), n);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin : stim
        logic [15:0] pat;
        int unsigned issued;
        pat = 16'b1011_0011_1001_0110;

        rst_b              = 1'b1;
        flush              = 1'b0;
        bus.pc_valid       = 1'b1;
        bus.pc             = 32'h0;
        bus.imem_req_ready = 1'b1;
        bus.inst_ready     = 1'b0;
        #3;
        chk("reset_inst_valid", {31'b0, bus.inst_valid}, 32'h0);
        chk("reset_pc_ready", {31'b0, bus.pc_ready}, 32'h0);
        chk("reset_req_valid", {31'b0, bus.imem_req_valid}, 32'h0);
        chk("reset_inst", bus.inst, 32'h0);
        chk("reset_inst_pc", bus.inst_pc, 32'h0);
        cyc();
        cyc();
        rst_b        = 1'b0;
        bus.pc_valid = 1'b0;
        cyc();

        // Basic fetch with 1-cycle memory
        mem_en         = 1'b1;
        bus.inst_ready = 1'b1;
        bus.pc_valid   = 1'b1;
        bus.pc         = 32'h0;
        settle();
        chk("basic_pc_ready", {31'b0, bus.pc_ready}, 32'h1);
        chk("basic_req_addr", bus.imem_req_addr, 32'h0);
        cyc();
        bus.pc = 32'h4;
        settle();
        chk("basic_no_bypass", {31'b0, bus.inst_valid}, 32'h0);
        cyc();
        bus.pc = 32'h8;
        settle();
        chk("basic_first_valid", {31'b0, bus.inst_valid}, 32'h1);
        chk("basic_pc0", bus.inst_pc, 32'h0);
        chk("basic_word0", bus.inst, 32'hC0DE_0000);
        cyc();
        bus.pc_valid = 1'b0;
        settle();
        chk("basic_pc4", bus.inst_pc, 32'h4);
        cyc();
        settle();
        chk("basic_pc8", bus.inst_pc, 32'h8);
        chk("basic_word8", bus.inst, 32'hC0DE_0008);
        cyc();
        bus.pc_valid       = 1'b1;
        bus.pc             = 32'hC;
        bus.imem_req_ready = 1'b0;
        settle();
        chk("mem_stall_pc_ready", {31'b0, bus.pc_ready}, 32'h0);
        chk("mem_stall_req_valid", {31'b0, bus.imem_req_valid}, 32'h1);
        cyc();
        bus.pc_valid       = 1'b0;
        bus.imem_req_ready = 1'b1;
        cyc();

        // Full queue and space release
        bus.inst_ready = 1'b0;
        for (int unsigned i = 0; i < 4; i++) begin
            bus.pc_valid = 1'b1;
            bus.pc       = 32'h10 + 4 * i;
            settle();
            chk("full_fill_ready", {31'b0, bus.pc_ready}, 32'h1);
            cyc();
        end
        bus.pc = 32'h20;
        settle();
        chk("full_pc_ready", {31'b0, bus.pc_ready}, 32'h0);
        cyc();
        bus.inst_ready = 1'b1;
        settle();
        chk("pop_cycle_pc_ready", {31'b0, bus.pc_ready}, 32'h0);
        chk("full_head_pc", bus.inst_pc, 32'h10);
        cyc();
        bus.inst_ready = 1'b0;
        settle();
        chk("after_pop_pc_ready", {31'b0, bus.pc_ready}, 32'h1);
        cyc();
        bus.pc_valid = 1'b0;
        collect(4, 20, "full_drain");
        for (int i = 0; i < got.size() && i < 4; i++)
            chk("full_order", got[i], 32'h14 + 4 * i);

        // Wrap: 10 sequential fetches with a fixed ready pattern
        issued = 0;
        got.delete();
        for (int c = 0; c < 100 && got.size() < 10; c++) begin
            bus.pc_valid   = (issued < 10);
            bus.pc         = 32'h300 + 4 * issued;
            bus.inst_ready = pat[c % 16];
            settle();
            if (bus.pc_valid && bus.pc_ready) issued++;
            if (bus.inst_valid && bus.inst_ready) got.push_back(bus.inst_pc);
            cyc();
        end
        bus.pc_valid   = 1'b0;
        bus.inst_ready = 1'b0;
        chk("wrap_count", got.size(), 10);
        for (int i = 0; i < got.size(); i++)
            chk("wrap_order", got[i], 32'h300 + 4 * i);
        cyc();

        // Flush with two in flight and one buffered
        bus.pc_valid = 1'b1;
        bus.pc       = 32'h40;
        settle();
        cyc();
        bus.pc = 32'h44;
        settle();
        cyc();
        mem_en = 1'b0;
        bus.pc = 32'h48;
        settle();
        chk("pre_flush_head", {31'b0, bus.inst_valid}, 32'h1);
        cyc();
        bus.pc = 32'h4C;
        flush  = 1'b1;
        settle();
        chk("flush_inst_valid", {31'b0, bus.inst_valid}, 32'h0);
        chk("flush_pc_ready", {31'b0, bus.pc_ready}, 32'h0);
        chk("flush_req_valid", {31'b0, bus.imem_req_valid}, 32'h0);
        cyc();
        flush  = 1'b0;
        mem_en = 1'b1;
        bus.pc = 32'h100;
        settle();
        chk("post_flush_pc_ready", {31'b0, bus.pc_ready}, 32'h1);
        chk("post_flush_empty", {31'b0, bus.inst_valid}, 32'h0);
        cyc();
        bus.pc_valid = 1'b0;
        collect(1, 12, "flush_drop");
        if (got.size() > 0) chk("flush_first_pc", got[0], 32'h100);

        // Flush coincident with the only in-flight response
        bus.pc_valid = 1'b1;
        bus.pc       = 32'h200;
        settle();
        cyc();
        bus.pc_valid = 1'b0;
        flush        = 1'b1;
        settle();
        cyc();
        flush        = 1'b0;
        bus.pc_valid = 1'b1;
        bus.pc       = 32'h204;
        settle();
        cyc();
        bus.pc_valid = 1'b0;
        collect(1, 8, "flush_rsp");
        if (got.size() > 0) chk("flush_rsp_pc", got[0], 32'h204);

        // Async reset with three buffered entries
        for (int unsigned i = 0; i < 3; i++) begin
            bus.pc_valid = 1'b1;
            bus.pc       = 32'h500 + 4 * i;
            cyc();
        end
        bus.pc_valid = 1'b0;
        cyc();
        settle();
        chk("pre_reset_valid", {31'b0, bus.inst_valid}, 32'h1);
        cyc();
        bus.pc_valid = 1'b1;
        bus.pc       = 32'h50C;
        rst_b        = 1'b1;
        #1;
        chk("async_rst_inst_valid", {31'b0, bus.inst_valid}, 32'h0);
        chk("async_rst_pc_ready", {31'b0, bus.pc_ready}, 32'h0);
        chk("async_rst_req_valid", {31'b0, bus.imem_req_valid}, 32'h0);
        chk("async_rst_inst", bus.inst, 32'h0);
        chk("async_rst_inst_pc", bus.inst_pc, 32'h0);
        cyc();
        rst_b        = 1'b0;
        bus.pc_valid = 1'b0;
        cyc();
        bus.pc_valid = 1'b1;
        bus.pc       = 32'h600;
        cyc();
        bus.pc_valid = 1'b0;
        collect(1, 8, "post_reset");
        if (got.size() > 0) chk("post_reset_pc", got[0], 32'h600);
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
